// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: converts the LSU's single-outstanding io_* memory port into
// AXI4-Lite master transactions (one transaction in flight).
// Ports:
//   clock, reset                       rising-edge clock, async active-high reset
//   io_reqValid/io_addr/io_wdata/
//   io_wmask/io_size/io_wen            request from the LSU (sampled only in IDLE)
//   io_respValid/io_rdata/io_err       registered one-cycle completion
//   m_aw*/m_w*/m_b*/m_ar*/m_r*         AXI4-Lite master channels
module mem_axi_bridge #(
  parameter bit          ALIGN_ADDR = 1'b1,
  parameter logic [31:0] ERR_RDATA  = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_reqValid,
  output logic        io_respValid,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic [31:0] io_addr,
  input  logic [1:0]  io_size,
  input  logic        io_wen,
  input  logic [3:0]  io_wmask,
  output logic        io_err,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awsize,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arsize,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned ZW = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [AW-1:0] r_addr, w_nxt_addr;
  logic [DW-1:0] r_wdata, w_nxt_wdata;
  logic [SW-1:0] r_wmask, w_nxt_wmask;
  logic [ZW-1:0] r_axsize, w_nxt_axsize;
  logic          r_awvalid, w_nxt_awvalid;
  logic          r_wvalid, w_nxt_wvalid;
  logic          r_bready, w_nxt_bready;
  logic          r_arvalid, w_nxt_arvalid;
  logic          r_rready, w_nxt_rready;
  logic          r_resp_valid, w_nxt_resp_valid;
  logic          r_err, w_nxt_err;
  logic [DW-1:0] r_rdata, w_nxt_rdata;
  logic          w_aw_ok, w_w_ok;

  // A channel is finished once its valid has dropped or is handshaking now
  assign w_aw_ok = ~r_awvalid | m_awready;
  assign w_w_ok  = ~r_wvalid  | m_wready;

  // State register and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_axsize     <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_addr       <= w_nxt_addr;
      r_wdata      <= w_nxt_wdata;
      r_wmask      <= w_nxt_wmask;
      r_axsize     <= w_nxt_axsize;
      r_awvalid    <= w_nxt_awvalid;
      r_wvalid     <= w_nxt_wvalid;
      r_bready     <= w_nxt_bready;
      r_arvalid    <= w_nxt_arvalid;
      r_rready     <= w_nxt_rready;
      r_resp_valid <= w_nxt_resp_valid;
      r_err        <= w_nxt_err;
      r_rdata      <= w_nxt_rdata;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_addr       = r_addr;
    w_nxt_wdata      = r_wdata;
    w_nxt_wmask      = r_wmask;
    w_nxt_axsize     = r_axsize;
    w_nxt_awvalid    = r_awvalid;
    w_nxt_wvalid     = r_wvalid;
    w_nxt_bready     = r_bready;
    w_nxt_arvalid    = r_arvalid;
    w_nxt_rready     = r_rready;
    w_nxt_resp_valid = 1'b0;
    w_nxt_err        = 1'b0;
    w_nxt_rdata      = r_rdata;

    case (r_state)
      S_IDLE: begin
        if (io_reqValid) begin
          w_nxt_addr   = ALIGN_ADDR ? {io_addr[AW-1:2], 2'b00} : io_addr;
          w_nxt_wdata  = io_wdata;
          w_nxt_wmask  = io_wmask;
          // Size 3 has no meaning on a 32-bit bus; treat it as a word
          w_nxt_axsize = (io_size == 2'd3) ? ZW'(2) : {1'b0, io_size};
          if (io_wen) begin
            w_nxt_state   = S_WR_REQ;
            w_nxt_awvalid = 1'b1;
            w_nxt_wvalid  = 1'b1;
          end else begin
            w_nxt_state   = S_RD_REQ;
            w_nxt_arvalid = 1'b1;
          end
        end
      end

      S_WR_REQ: begin
        if (r_awvalid && m_awready) w_nxt_awvalid = 1'b0;
        if (r_wvalid && m_wready)   w_nxt_wvalid  = 1'b0;
        if (w_aw_ok && w_w_ok) begin
          w_nxt_state  = S_WR_RESP;
          w_nxt_bready = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (m_bvalid) begin
          w_nxt_state      = S_DONE;
          w_nxt_bready     = 1'b0;
          w_nxt_resp_valid = 1'b1;
          w_nxt_err        = (m_bresp != 2'b00);
        end
      end

      S_RD_REQ: begin
        if (m_arready) begin
          w_nxt_state   = S_RD_RESP;
          w_nxt_arvalid = 1'b0;
          w_nxt_rready  = 1'b1;
        end
      end

      S_RD_RESP: begin
        if (m_rvalid) begin
          w_nxt_state      = S_DONE;
          w_nxt_rready     = 1'b0;
          w_nxt_resp_valid = 1'b1;
          w_nxt_err        = (m_rresp != 2'b00);
          w_nxt_rdata      = (m_rresp == 2'b00) ? m_rdata : ERR_RDATA;
        end
      end

      S_DONE: begin
        w_nxt_state = S_IDLE;
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  assign io_respValid = r_resp_valid;
  assign io_err       = r_err;
  assign io_rdata     = r_rdata;
  assign m_awvalid    = r_awvalid;
  assign m_awaddr     = r_addr;
  assign m_awsize     = r_axsize;
  assign m_wvalid     = r_wvalid;
  assign m_wdata      = r_wdata;
  assign m_wstrb      = r_wmask;
  assign m_bready     = r_bready;
  assign m_arvalid    = r_arvalid;
  assign m_araddr     = r_addr;
  assign m_arsize     = r_axsize;
  assign m_rready     = r_rready;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb_mem_axi_bridge: drives LSU requests into mem_axi_bridge, plays a reactive
// AXI4-Lite slave with configurable stall counts, and compares every cycle's
// channel activity against cycle numbers derived from the transaction timing.
module tb_mem_axi_bridge;

  localparam logic [31:0] ERR_VAL = 32'hE77E_0BAD;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_reqValid, io_respValid, io_wen, io_err;
  logic [31:0] io_wdata, io_rdata, io_addr;
  logic [1:0]  io_size;
  logic [3:0]  io_wmask;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awsize, m_arsize;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata = 32'h0;

  mem_axi_bridge #(.ALIGN_ADDR(1'b1), .ERR_RDATA(ERR_VAL)) dut (
    .clock(clock), .reset(reset),
    .io_reqValid(io_reqValid), .io_respValid(io_respValid),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_addr(io_addr),
    .io_size(io_size), .io_wen(io_wen), .io_wmask(io_wmask), .io_err(io_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hs_vec();
    return 32'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, io_respValid});
  endfunction

  task automatic slave_idle();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
  endtask

  // One LSU transaction. Called and returning at a negedge while the bridge is
  // idle (or finishing a DONE cycle with the next request already presented).
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [1:0] size,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input int ar_dly, input int r_dly,
                         input logic [1:0] resp, input logic [31:0] rdata,
                         input bit hold, input logic [31:0] nxt_addr);
    logic [31:0] exp_addr;
    logic [31:0] exp_sz;
    logic        exp_err;
    logic [5:0]  exp_hs;
    int          m, done_cyc, aw_cyc, w_cyc, ar_cyc;
    bit          aw_done, w_done, b_done, ar_done, r_done;
    exp_addr = addr & 32'hFFFF_FFFC;
    exp_sz   = (size == 2'd3) ? 32'd2 : 32'(size);
    exp_err  = (resp != 2'b00);
    m        = (aw_dly > w_dly) ? aw_dly : w_dly;
    done_cyc = wen ? (m + b_dly + 2) : (ar_dly + r_dly + 2);
    if (!wen) last_rdata = (resp == 2'b00) ? rdata : ERR_VAL;
    aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0;

    io_reqValid = 1'b1; io_wen = wen; io_addr = addr; io_wdata = wdata;
    io_wmask = wmask; io_size = size;
    @(posedge clock); @(negedge clock);
    // Inputs after acceptance must not matter
    io_reqValid = 1'b0; io_wen = 1'($urandom); io_addr = $urandom;
    io_wdata = $urandom; io_wmask = 4'($urandom); io_size = 2'($urandom);

    for (int cyc = 0; cyc <= done_cyc + 1; cyc++) begin
      exp_hs = {wen && cyc <= aw_dly,
                wen && cyc <= w_dly,
                wen && cyc >= m + 1 && cyc <= m + 1 + b_dly,
                !wen && cyc <= ar_dly,
                !wen && cyc >= ar_dly + 1 && cyc <= ar_dly + 1 + r_dly,
                cyc == done_cyc};
      check("handshake", hs_vec(), 32'(exp_hs));
      if (m_awvalid) begin
        check("awaddr", m_awaddr, exp_addr);
        check("awsize", 32'(m_awsize), exp_sz);
      end
      if (m_wvalid) begin
        check("wdata", m_wdata, wdata);
        check("wstrb", 32'(m_wstrb), 32'(wmask));
      end
      if (m_arvalid) begin
        check("araddr", m_araddr, exp_addr);
        check("arsize", 32'(m_arsize), exp_sz);
      end
      if (cyc == done_cyc) begin
        check("rdata", io_rdata, last_rdata);
        check("err", 32'(io_err), 32'(exp_err));
        if (hold) begin
          io_reqValid = 1'b1; io_wen = 1'b0; io_addr = nxt_addr;
          io_size = 2'd2; io_wmask = 4'h0; io_wdata = 32'h0;
        end
      end
      // Reactive slave
      m_awready = wen && !aw_done && cyc >= aw_dly;
      m_wready  = wen && !w_done && cyc >= w_dly;
      m_bvalid  = aw_done && w_done && !b_done &&
                  cyc > ((aw_cyc > w_cyc) ? aw_cyc : w_cyc) + b_dly;
      m_bresp   = m_bvalid ? resp : 2'b00;
      m_arready = !wen && !ar_done && cyc >= ar_dly;
      m_rvalid  = ar_done && !r_done && cyc > ar_cyc + r_dly;
      m_rdata   = m_rvalid ? rdata : $urandom;
      m_rresp   = m_rvalid ? resp : 2'b00;
      if (m_awvalid && m_awready) begin aw_done = 1; aw_cyc = cyc; end
      if (m_wvalid && m_wready)   begin w_done = 1;  w_cyc = cyc;  end
      if (m_bvalid && m_bready)   b_done = 1;
      if (m_arvalid && m_arready) begin ar_done = 1; ar_cyc = cyc; end
      if (m_rvalid && m_rready)   r_done = 1;
      if (cyc < done_cyc + 1) begin
        @(posedge clock); @(negedge clock);
      end
    end
    slave_idle();
  endtask

  initial begin
    logic        r_wen;
    logic [1:0]  r_resp;
    reset = 1'b1;
    io_reqValid = 1'b0; io_wen = 1'b0; io_addr = 32'h0; io_wdata = 32'h0;
    io_wmask = 4'h0; io_size = 2'd0;
    slave_idle();
    repeat (2) @(negedge clock);
    check("reset_hs", hs_vec(), 32'h0);
    check("reset_rdata", io_rdata, 32'h0);
    check("reset_err", 32'(io_err), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Aligned read, minimum latency
    run_txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, 2'd2, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 32'h0);
    // Store byte at an unaligned address
    run_txn(1'b1, 32'h8000_0003, 32'hAA00_0000, 4'b1000, 2'd0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 32'h0);
    // W handshake three cycles after AW
    run_txn(1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, 2'd2, 0, 3, 0, 0, 0, 2'b00, 32'h0, 0, 32'h0);
    // Read with SLVERR
    run_txn(1'b0, 32'h8000_0040, 32'h0, 4'h0, 2'd2, 0, 0, 0, 0, 1, 2'b10, 32'h5555_AAAA, 0, 32'h0);
    // Back-to-back: request level held through the pulse
    run_txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, 2'd2, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 1, 32'h8000_0008);
    run_txn(1'b0, 32'h8000_0008, 32'h0, 4'h0, 2'd2, 1, 0, 0, 0, 0, 2'b00, 32'hC0DE_0008, 0, 32'h0);
    // AW later than W, stalled B with error; rdata must be left alone
    run_txn(1'b1, 32'h8000_0102, 32'h0000_BEEF, 4'b0011, 2'd1, 2, 0, 2, 0, 0, 2'b11, 32'h0, 0, 32'h0);
    // Size 3 presented as a word
    run_txn(1'b1, 32'h8000_0200, 32'hCAFE_CAFE, 4'hF, 2'd3, 1, 1, 0, 0, 0, 2'b00, 32'h0, 0, 32'h0);

    // Reset while waiting for R
    io_reqValid = 1'b1; io_wen = 1'b0; io_addr = 32'h8000_0010; io_size = 2'd2;
    @(posedge clock); @(negedge clock);
    io_reqValid = 1'b0;
    check("rst_arvalid", hs_vec(), 32'b000100);
    m_arready = 1'b1;
    @(posedge clock); @(negedge clock);
    m_arready = 1'b0;
    check("rst_rready", hs_vec(), 32'b000010);
    reset = 1'b1;
    #1;
    check("rst_async_hs", hs_vec(), 32'h0);
    check("rst_async_rdata", io_rdata, 32'h0);
    check("rst_async_err", 32'(io_err), 32'h0);
    last_rdata = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_idle", hs_vec(), 32'h0);
    run_txn(1'b0, 32'h8000_0014, 32'h0, 4'h0, 2'd2, 0, 0, 0, 1, 0, 2'b00, 32'h7777_1111, 0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r_wen  = 1'($urandom);
      r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(r_wen, $urandom, $urandom, 4'($urandom), 2'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), r_resp, $urandom,
              0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
